// File: rtl/dram_stream_pkg.sv
// Shared types and constants for the DRAM-side byte-stream endpoint.
// The word is split into LANES byte lanes, with lane 0 in the least-significant bits.
package dram_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND_BYTES,
        ST_WR_COLLECT,
        ST_WR_REQ,
        ST_DONE
    } state_t;

    localparam logic DIR_SEND    = 1'b0;
    localparam logic DIR_RECEIVE = 1'b1;

    localparam int LANES      = 4;
    localparam int LANE_IDX_W = $clog2(LANES);
    localparam int WORD_WIDTH = 32;

    localparam logic [LANES-1:0] FULL_MASK = 4'b1111;

endpackage

// File: rtl/dram_stream_port_if.sv
// Command, DRAM and byte-stream signals of the endpoint, bundled together.
// The master modport is the port itself; the slave modport is its environment.
interface dram_stream_port_if
    import dram_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DRAM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH       = 16
);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_dir;
    logic [DRAM_ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]       cmd_len;
    logic                       busy;
    logic                       done;

    logic                       dram_req;
    logic                       dram_we;
    logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
    logic [WORD_WIDTH-1:0]      dram_wdata;
    logic [LANES-1:0]           dram_wmask;
    logic                       dram_gnt;
    logic                       dram_rvalid;
    logic [WORD_WIDTH-1:0]      dram_rdata;

    logic [DATA_WIDTH-1:0]      rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic [DATA_WIDTH-1:0]      tx_data;
    logic                       tx_valid;
    logic                       tx_ready;

    modport master (
        input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
        input  dram_gnt, dram_rvalid, dram_rdata,
        input  rx_ready, tx_data, tx_valid,
        output cmd_ready, busy, done,
        output dram_req, dram_we, dram_addr, dram_wdata, dram_wmask,
        output rx_data, rx_valid, tx_ready
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_addr, cmd_len,
        output dram_gnt, dram_rvalid, dram_rdata,
        output rx_ready, tx_data, tx_valid,
        input  cmd_ready, busy, done,
        input  dram_req, dram_we, dram_addr, dram_wdata, dram_wmask,
        input  rx_data, rx_valid, tx_ready
    );

endinterface

// File: rtl/stream_byte_lane_ctrl.sv
// Byte-lane bookkeeping shared by both directions: current lane, collected-lane
// mask and bytes remaining, plus the "word complete" and "last byte" flags.
module stream_byte_lane_ctrl
    import dram_stream_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_step,
    input  logic                  i_clear_mask,
    output logic [LANE_IDX_W-1:0] o_lane,
    output logic [LANES-1:0]      o_mask,
    output logic                  o_word_done,
    output logic                  o_last,
    output logic                  o_empty
);

    logic [LANE_IDX_W-1:0] r_lane;
    logic [LANES-1:0]      r_mask;
    logic [LEN_WIDTH-1:0]  r_remaining;

    logic w_word_done;

    assign w_word_done = (r_lane == LANE_IDX_W'(LANES - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane      <= '0;
            r_mask      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_lane      <= '0;
            r_mask      <= '0;
            r_remaining <= i_len;
        end else begin
            if (i_step) begin
                r_mask[r_lane] <= 1'b1;
                r_lane         <= w_word_done ? '0 : r_lane + 1'b1;
                r_remaining    <= r_remaining - 1'b1;
            end
            if (i_clear_mask) begin
                r_mask <= '0;
            end
        end
    end

    assign o_lane      = r_lane;
    assign o_mask      = r_mask;
    assign o_word_done = w_word_done;
    assign o_last      = (r_remaining == LEN_WIDTH'(1));
    assign o_empty     = (r_remaining == '0);

endmodule

// File: rtl/dram_stream_port.sv
// DRAM-side endpoint of the loader byte stream: SEND unpacks DRAM words onto rx,
// RECEIVE packs tx bytes into masked DRAM word writes. One command at a time.
module dram_stream_port
    import dram_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DRAM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH       = 16
) (
    input  logic               clk,
    input  logic               rst,
    dram_stream_port_if.master bus
);

    state_t                     r_state;
    state_t                     w_next;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr;
    logic                       r_dir;
    logic [WORD_WIDTH-1:0]      r_word;

    logic [LANE_IDX_W-1:0] w_lane;
    logic [LANES-1:0]      w_mask;
    logic                  w_word_done;
    logic                  w_last;
    logic                  w_empty;

    logic                  w_cmd_fire;
    logic                  w_rx_valid;
    logic                  w_tx_ready;
    logic                  w_rx_fire;
    logic                  w_tx_fire;
    logic                  w_wr_gnt;
    logic [DATA_WIDTH-1:0] w_lane_byte;

    assign w_cmd_fire  = bus.cmd_valid && (r_state == ST_IDLE);
    assign w_rx_valid  = (r_state == ST_SEND_BYTES) && (r_dir == DIR_SEND);
    assign w_tx_ready  = (r_state == ST_WR_COLLECT) && (r_dir == DIR_RECEIVE);
    assign w_rx_fire   = w_rx_valid && bus.rx_ready;
    assign w_tx_fire   = w_tx_ready && bus.tx_valid;
    assign w_wr_gnt    = (r_state == ST_WR_REQ) && bus.dram_gnt;
    assign w_lane_byte = r_word[int'(w_lane)*DATA_WIDTH +: DATA_WIDTH];

    stream_byte_lane_ctrl #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_lane_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_cmd_fire),
        .i_len        (bus.cmd_len),
        .i_step       (w_rx_fire || w_tx_fire),
        .i_clear_mask (w_wr_gnt),
        .o_lane       (w_lane),
        .o_mask       (w_mask),
        .o_word_done  (w_word_done),
        .o_last       (w_last),
        .o_empty      (w_empty)
    );

    // NOTE: the next-state default is assigned first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if (bus.cmd_len == '0)            w_next = ST_DONE;
                    else if (bus.cmd_dir == DIR_SEND) w_next = ST_RD_REQ;
                    else                              w_next = ST_WR_COLLECT;
                end
            end
            ST_RD_REQ: begin
                if (bus.dram_gnt) w_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.dram_rvalid) w_next = ST_SEND_BYTES;
            end
            ST_SEND_BYTES: begin
                if (w_rx_fire) begin
                    if (w_last)           w_next = ST_DONE;
                    else if (w_word_done) w_next = ST_RD_REQ;
                end
            end
            ST_WR_COLLECT: begin
                if (w_tx_fire && (w_last || w_word_done)) w_next = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (bus.dram_gnt) w_next = w_empty ? ST_DONE : ST_WR_COLLECT;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_dir   <= DIR_SEND;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            if (w_cmd_fire) begin
                r_addr <= bus.cmd_addr;
                r_dir  <= bus.cmd_dir;
                r_word <= '0;
            end
            if ((r_state == ST_RD_WAIT) && bus.dram_rvalid) begin
                r_word <= bus.dram_rdata;
            end
            if (w_tx_fire) begin
                r_word[int'(w_lane)*DATA_WIDTH +: DATA_WIDTH] <= bus.tx_data;
            end
            // Address advances only when another word follows; wraps at the top.
            if (w_rx_fire && w_word_done && !w_last) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_wr_gnt) begin
                r_word <= '0;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.dram_req   = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
    assign bus.dram_we    = (r_state == ST_WR_REQ);
    assign bus.dram_addr  = r_addr;
    assign bus.dram_wdata = (r_state == ST_WR_REQ) ? r_word : '0;
    assign bus.dram_wmask = (r_state == ST_WR_REQ) ? w_mask : '0;
    assign bus.rx_valid   = w_rx_valid;
    assign bus.rx_data    = w_rx_valid ? w_lane_byte : '0;
    assign bus.tx_ready   = w_tx_ready;

endmodule

// File: tb/tb_dram_stream_port.sv
// Scoreboard bench for dram_stream_port: directed commands push expected DRAM
// accesses and rx bytes; a negedge monitor compares whatever the port presents.
module tb_dram_stream_port;
    import dram_stream_pkg::*;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } dram_exp_t;

    logic clk;
    logic rst;

    dram_stream_port_if #(.DATA_WIDTH(8), .DRAM_ADDR_WIDTH(16), .LEN_WIDTH(16)) bus ();

    dram_stream_port #(
        .DATA_WIDTH      (8),
        .DRAM_ADDR_WIDTH (16),
        .LEN_WIDTH       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    dram_exp_t   exp_dram[$];
    logic [7:0]  exp_rx[$];
    logic [31:0] mem [int];

    int done_cnt  = 0;
    int rx_count  = 0;
    bit tx_allowed = 1'b0;

    int rx_stall_at     = -1;
    int rx_stall_cycles = 0;
    int gnt_stall_cycles = 0;
    int gnt_tag          = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    initial begin
        dram_exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_dram.delete();
                exp_rx.delete();
            end else begin
                if (bus.dram_req) begin
                    if (exp_dram.size() == 0) begin
                        check("dram_req_unexpected", bus.dram_req, 1'b0);
                    end else begin
                        e = exp_dram[0];
                        check("dram_we", bus.dram_we, e.we);
                        check("dram_addr", bus.dram_addr, e.addr);
                        if (e.we) begin
                            check("dram_wdata", bus.dram_wdata, e.data);
                            check("dram_wmask", bus.dram_wmask, e.mask);
                        end
                        if (bus.dram_gnt) void'(exp_dram.pop_front());
                    end
                end
                if (bus.rx_valid) begin
                    if (exp_rx.size() == 0) begin
                        check("rx_valid_unexpected", bus.rx_valid, 1'b0);
                    end else begin
                        check("rx_data", bus.rx_data, exp_rx[0]);
                        if (bus.rx_ready) begin
                            void'(exp_rx.pop_front());
                            rx_count++;
                        end
                    end
                end
                if (!tx_allowed) check("tx_ready_isolation", bus.tx_ready, 1'b0);
                if (bus.done) done_cnt++;
            end
        end
    end

    // DRAM responder: grant after an optional stall, read data one cycle after grant
    initial begin
        bit          rd_pending = 1'b0;
        logic [15:0] rd_addr    = '0;
        int          seen_tag   = 0;
        int          stall_left = 0;
        bus.dram_gnt    = 1'b0;
        bus.dram_rvalid = 1'b0;
        bus.dram_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pending) begin
                bus.dram_rvalid = 1'b1;
                bus.dram_rdata  = mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 32'h0;
                rd_pending      = 1'b0;
            end else begin
                bus.dram_rvalid = 1'b0;
                bus.dram_rdata  = '0;
            end
            if (gnt_tag != seen_tag) begin
                seen_tag   = gnt_tag;
                stall_left = gnt_stall_cycles;
            end
            if (bus.dram_req && !rst) begin
                if (stall_left > 0) begin
                    bus.dram_gnt = 1'b0;
                    stall_left--;
                end else begin
                    bus.dram_gnt = 1'b1;
                    if (!bus.dram_we) begin
                        rd_pending = 1'b1;
                        rd_addr    = bus.dram_addr;
                    end
                end
            end else begin
                bus.dram_gnt = 1'b0;
            end
        end
    end

    // rx sink: ready by default, optionally withheld for a few cycles on one byte
    initial begin
        int last_at = -1;
        int used    = 0;
        bus.rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rx_stall_at != last_at) begin
                last_at = rx_stall_at;
                used    = 0;
            end
            if (bus.rx_valid && (rx_count == rx_stall_at) && (used < rx_stall_cycles)) begin
                bus.rx_ready = 1'b0;
                used++;
            end else begin
                bus.rx_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_rd(input logic [15:0] addr);
        dram_exp_t e;
        e.we = 1'b0; e.addr = addr; e.data = '0; e.mask = '0;
        exp_dram.push_back(e);
    endtask

    task automatic push_wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] mask);
        dram_exp_t e;
        e.we = 1'b1; e.addr = addr; e.data = data; e.mask = mask;
        exp_dram.push_back(e);
    endtask

    task automatic issue_cmd(input logic dir, input logic [15:0] addr, input logic [15:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        bus.cmd_dir   = dir;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n = 0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_ready_wait", bus.tx_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int exp_cnt, input int budget);
        int n = 0;
        while (done_cnt < exp_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, exp_cnt);
    endtask

    task automatic check_idle_outputs();
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_done", bus.done, 1'b0);
        check("idle_dram_req", bus.dram_req, 1'b0);
        check("idle_dram_we", bus.dram_we, 1'b0);
        check("idle_dram_addr", bus.dram_addr, 16'h0);
        check("idle_dram_wdata", bus.dram_wdata, 32'h0);
        check("idle_dram_wmask", bus.dram_wmask, 4'h0);
        check("idle_rx_valid", bus.rx_valid, 1'b0);
        check("idle_rx_data", bus.rx_data, 8'h0);
        check("idle_tx_ready", bus.tx_ready, 1'b0);
    endtask

    task automatic check_drained();
        check("dram_queue_drained", exp_dram.size(), 0);
        check("rx_queue_drained", exp_rx.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] rx_bytes1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic [7:0] rx_bytes2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        logic [7:0] tx_bytes3 [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

        rst          = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = DIR_SEND;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;

        mem[32'h0010] = 32'h44332211;
        mem[32'h0011] = 32'h88776655;
        mem[32'h0020] = 32'hDDCCBBAA;
        mem[32'h0021] = 32'h44332211;
        mem[32'h0300] = 32'h03020100;
        mem[32'h0301] = 32'h07060504;
        mem[32'h0400] = 32'hCAFEBABE;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs();

        // 1: SEND two full words
        push_rd(16'h0010);
        push_rd(16'h0011);
        foreach (rx_bytes1[i]) exp_rx.push_back(rx_bytes1[i]);
        issue_cmd(DIR_SEND, 16'h0010, 16'd8);
        wait_done(1, 300);
        check_drained();

        // 2: SEND 5 bytes with a 3-cycle stall on byte 2
        rx_stall_cycles = 3;
        rx_stall_at     = rx_count + 2;
        push_rd(16'h0020);
        push_rd(16'h0021);
        foreach (rx_bytes2[i]) exp_rx.push_back(rx_bytes2[i]);
        issue_cmd(DIR_SEND, 16'h0020, 16'd5);
        wait_done(2, 300);
        check_drained();

        // 3: RECEIVE 6 bytes, full word then a 2-lane partial word
        tx_allowed = 1'b1;
        push_wr(16'h0200, 32'hA3A2A1A0, FULL_MASK);
        push_wr(16'h0201, 32'h0000A5A4, 4'b0011);
        issue_cmd(DIR_RECEIVE, 16'h0200, 16'd6);
        foreach (tx_bytes3[i]) send_tx(tx_bytes3[i]);
        bus.tx_valid = 1'b0;
        wait_done(3, 300);
        check_drained();

        // 4: write grant withheld for 4 cycles; request must hold steady
        gnt_stall_cycles = 4;
        gnt_tag++;
        push_wr(16'h0500, 32'h04030201, FULL_MASK);
        issue_cmd(DIR_RECEIVE, 16'h0500, 16'd4);
        for (int i = 1; i <= 4; i++) send_tx(8'(i));
        bus.tx_valid = 1'b0;
        wait_done(4, 300);
        check_drained();
        tx_allowed       = 1'b0;
        gnt_stall_cycles = 0;
        gnt_tag++;

        // 5: zero length completes with no DRAM or stream activity
        issue_cmd(DIR_SEND, 16'h0600, 16'd0);
        wait_done(5, 4);
        repeat (4) @(negedge clk);
        check("len0_single_done", done_cnt, 5);
        check_drained();

        // 6: reset in the middle of a 16-byte SEND
        push_rd(16'h0300);
        for (int i = 0; i < 4; i++) exp_rx.push_back(8'(i));
        base = rx_count;
        issue_cmd(DIR_SEND, 16'h0300, 16'd16);
        n = 0;
        while (rx_count < base + 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reached_send_bytes", bus.rx_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs();
        repeat (5) @(negedge clk);
        check("no_done_after_reset", done_cnt, 5);

        push_rd(16'h0400);
        exp_rx.push_back(8'hBE);
        exp_rx.push_back(8'hBA);
        exp_rx.push_back(8'hFE);
        exp_rx.push_back(8'hCA);
        issue_cmd(DIR_SEND, 16'h0400, 16'd4);
        wait_done(6, 300);
        check_drained();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
